fir_decimator: RTL

FIR_DECIMATOR -- requirements
Module: fir_decimator

---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_decimator_if.sv | 33 +++
 rtl/fir_decimator_fifo.sv | 52 +++++
 rtl/fir_decimator.sv | 107 ++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and helpers for the decimating output stage of the FIR filter.
package fir_pkg;

  // Raw filter result width (8x8 product plus one growth bit) and output width.
  localparam int IN_WIDTH_C  = 17;
  localparam int OUT_WIDTH_C = 8;

  // Largest value representable in an unsigned field of the given width.
  function automatic int sat_limit(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// Sample input, output handshake and status bundle of the decimator.
interface fir_decimator_if
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = IN_WIDTH_C,
  parameter int OUT_WIDTH  = OUT_WIDTH_C,
  parameter int FIFO_DEPTH = 4
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [IN_WIDTH-1:0]  Data_In;
  logic                 sample_en;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;
  logic                 overflow_clr;
  logic [CNT_W-1:0]     fifo_count;

  // Producer/consumer side: drives samples and the read/clear strobes.
  modport master (
    output Data_In, sample_en, out_ready, overflow_clr,
    input  out_data, out_valid, overflow, fifo_count
  );

  // Decimator side.
  modport slave (
    input  Data_In, sample_en, out_ready, overflow_clr,
    output out_data, out_valid, overflow, fifo_count
  );

endinterface

// File: rtl/fir_decimator_fifo.sv
// Small power-of-two output buffer. A push into a full buffer is only taken
// when a pop happens on the same edge; the head reads as zero when empty.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign count     = r_count;
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

  // Pointers wrap naturally at DEPTH; occupancy tracks net push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // Storage array; contents are qualified by the pointers so need no reset.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fir_decimator.sv
// Keeps one of every DECIM filter results, rounds and scales it down to
// OUT_WIDTH bits with saturation, and queues it for a ready/valid consumer.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = IN_WIDTH_C,
  parameter int OUT_WIDTH  = OUT_WIDTH_C,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 9,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clock,
  input logic            reset,
  fir_decimator_if.slave bus
);

  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IN_WIDTH:0] ROUND_C = (IN_WIDTH+1)'(1) << (SHIFT - 1);
  localparam logic [IN_WIDTH:0] SAT_C   = (IN_WIDTH+1)'(sat_limit(OUT_WIDTH));
  localparam logic [PH_W-1:0]   PH_LAST = PH_W'(DECIM - 1);

  // Round half up, computed one bit wider than the input so the bias never wraps.
  function automatic logic [IN_WIDTH:0] round_shift(input logic [IN_WIDTH-1:0] x);
    logic [IN_WIDTH:0] sum;
    sum = {1'b0, x} + ROUND_C;
    return sum >> SHIFT;
  endfunction

  // Clamp to the largest OUT_WIDTH-bit code.
  function automatic logic [OUT_WIDTH-1:0] saturate(input logic [IN_WIDTH:0] v);
    return (v > SAT_C) ? {OUT_WIDTH{1'b1}} : OUT_WIDTH'(v);
  endfunction

  logic [PH_W-1:0]      r_phase;
  logic                 w_accept_p0;
  logic [OUT_WIDTH-1:0] w_data_p0;
  logic                 r_vld_p1;
  logic [OUT_WIDTH-1:0] r_data_p1;
  logic                 r_overflow;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [OUT_WIDTH-1:0] w_head;
  logic [CNT_W-1:0]     w_count;

  // p0: decimation select and scaling
  assign w_accept_p0 = bus.sample_en && (r_phase == '0);
  assign w_data_p0   = saturate(round_shift(bus.Data_In));

  // Phase advances on every input sample, kept or not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else if (bus.sample_en) begin
      r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
    end
  end

  // p1: scaled sample register feeding the buffer on the following edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1 <= w_accept_p0;
      if (w_accept_p0) r_data_p1 <= w_data_p0;
    end
  end

  // p2: output buffer
  assign w_pop  = !w_empty && bus.out_ready;
  assign w_drop = r_vld_p1 && w_full && !w_pop;

  sample_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (r_vld_p1),
    .pop   (w_pop),
    .wdata (r_data_p1),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Sticky drop flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.out_data   = w_head;
  assign bus.out_valid  = !w_empty;
  assign bus.overflow   = r_overflow;
  assign bus.fifo_count = w_count;

endmodule
